// File: rtl/jt1942_prog_sdram.sv
// ---------------------------------------------------------------------------
// jt1942_prog_sdram
// Receiving end of the ROM-download programming bus. Byte writes from the
// download demux go into a small circular FIFO. A two-state FSM then issues
// 16-bit masked write requests to the SDRAM controller over a req/ack
// handshake. Writes to the PROM page are skipped here because prom_we
// handles them. dl_done pulses once the download is fully committed.
//
// Handshake: sdram_req is raised with sdram_addr/din/wrmask valid. All four
// stay stable until the controller returns a one-cycle sdram_ack, and the
// request is retired on that edge. The next queued write may be presented
// on the following cycle with sdram_req still high (back-to-back).
//
// Ports
//   clk_rom       in   ROM/SDRAM clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   downloading   in   high while the ROM download is in progress
//   prog_we       in   one-cycle write strobe for prog_addr/data/mask
//   prog_addr     in   [21:0] 16-bit word address
//   prog_data     in   [7:0]  byte to write
//   prog_mask     in   [1:0]  byte enables, [1]=upper, [0]=lower
//   sdram_req     out  write request to the SDRAM controller
//   sdram_ack     in   controller accepted the current request
//   sdram_addr    out  [21:0] word address of the current request
//   sdram_din     out  [15:0] write data, byte replicated in both halves
//   sdram_wrmask  out  [1:0]  byte enables of the current request
//   busy          out  FIFO non-empty or request outstanding (registered)
//   overflow      out  sticky flag: a write was dropped on a full FIFO
//   dl_done       out  one-cycle pulse when the download is fully committed
// ---------------------------------------------------------------------------
module jt1942_prog_sdram #(
  parameter int         FIFO_AW   = 2,
  parameter logic [3:0] PROM_PAGE = 4'hF
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        prog_we,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic [21:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_wrmask,
  output logic        busy,
  output logic        overflow,
  output logic        dl_done
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE_C   = (FIFO_AW + 1)'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  // Entry layout: {addr[21:0], data[7:0], mask[1:0]}
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  state_t             state;
  logic               downloading_q;
  logic               dl_pending;

  logic        push_req;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;
  logic        dl_rise;
  logic [31:0] head;
  logic [31:0] next_entry;

  always_comb begin
    push_req   = prog_we && (prog_mask != 2'b00) && (prog_addr[21:18] != PROM_PAGE);
    pop        = (state == ST_WAIT) && sdram_ack;
    full       = (count == DEPTH_C);
    // A full FIFO still accepts when the head leaves on the same edge.
    push_ok    = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    dl_rise    = downloading && !downloading_q;
    head       = mem[rd_ptr];
    next_entry = mem[rd_ptr + 1'b1];
  end

  // Storage carries no reset: emptiness is defined by the pointers/count.
  always_ff @(posedge clk_rom) begin
    if (push_ok) mem[wr_ptr] <= {prog_addr, prog_data, prog_mask};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  // Request FSM with registered request outputs
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sdram_req    <= 1'b0;
      sdram_addr   <= '0;
      sdram_din    <= '0;
      sdram_wrmask <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != '0) begin
            sdram_addr   <= head[31:10];
            sdram_din    <= {head[9:2], head[9:2]};
            sdram_wrmask <= head[1:0];
            sdram_req    <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdram_ack) begin
            // The head is retired this edge; the entry behind it becomes
            // the next request without dropping sdram_req.
            if (count > ONE_C) begin
              sdram_addr   <= next_entry[31:10];
              sdram_din    <= {next_entry[9:2], next_entry[9:2]};
              sdram_wrmask <= next_entry[1:0];
            end else begin
              sdram_req <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          sdram_req <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags and download-complete detection
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      overflow      <= 1'b0;
      dl_done       <= 1'b0;
      dl_pending    <= 1'b0;
      downloading_q <= 1'b0;
    end else begin
      downloading_q <= downloading;
      busy          <= (count != '0) || sdram_req;
      // A fresh download clears the sticky flag; a drop on that same
      // edge still sets it.
      if (dl_rise) overflow <= 1'b0;
      if (drop)    overflow <= 1'b1;
      dl_done <= 1'b0;
      if (dl_rise) begin
        dl_pending <= 1'b1;
      end else if (dl_pending && !downloading && (count == '0) && (state == ST_IDLE)) begin
        dl_done    <= 1'b1;
        dl_pending <= 1'b0;
      end
    end
  end

endmodule
